// File: rtl/rv_mem_pkg.sv
// rv_mem_pkg: shared width codes, port ids, response kinds and memory size
package rv_mem_pkg;
  localparam logic [3:0] W_BYTE = 4'd1;
  localparam logic [3:0] W_HALF = 4'd2;
  localparam logic [3:0] W_WORD = 4'd4;
  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;
  localparam int MEM_BYTES = 1024;
  typedef enum logic [1:0] {RK_READ, RK_WRITE, RK_ERR} resp_kind_t;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester ports and shared memory bus around the arbiter
interface mem_port_arbiter_if;
  logic        i_req, d_req;
  logic [31:0] i_addr, d_addr;
  logic [3:0]  i_width, d_width;
  logic        i_write, d_write;
  logic [31:0] i_wdata, d_wdata;
  logic        i_gnt, d_gnt;
  logic        i_rvalid, d_rvalid;
  logic [31:0] i_rdata, d_rdata;
  logic        i_err, d_err;
  logic [31:0] m_address;
  logic [3:0]  m_width;
  logic        m_write;
  logic [31:0] m_data_in;
  logic [31:0] m_data_out;
  modport master (
    output i_req, d_req, i_addr, d_addr, i_width, d_width, i_write, d_write, i_wdata, d_wdata, m_data_out,
    input  i_gnt, d_gnt, i_rvalid, d_rvalid, i_rdata, d_rdata, i_err, d_err, m_address, m_width, m_write, m_data_in
  );
  modport slave (
    input  i_req, d_req, i_addr, d_addr, i_width, d_width, i_write, d_write, i_wdata, d_wdata, m_data_out,
    output i_gnt, d_gnt, i_rvalid, d_rvalid, i_rdata, d_rdata, i_err, d_err, m_address, m_width, m_write, m_data_in
  );
endinterface

// File: rtl/mem_req_check.sv
// mem_req_check: flags a request legal when width, alignment and range are valid
module mem_req_check #(
  parameter int MEM_BYTES = rv_mem_pkg::MEM_BYTES
) (
  input  logic [31:0] addr,
  input  logic [3:0]  width,
  output logic        legal
);
  import rv_mem_pkg::*;
  always_comb
    legal = (width == W_BYTE || (width == W_HALF && !addr[0]) || (width == W_WORD && addr[1:0] == 2'b00))
            && addr < 32'(MEM_BYTES);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: data-priority arbiter with starvation guard for the instruction port
module mem_port_arbiter #(
  parameter int MAX_STARVE = 4,
  parameter int MEM_BYTES  = rv_mem_pkg::MEM_BYTES
) (
  input logic               clock,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);
  import rv_mem_pkg::*;
  localparam int SW = $clog2(MAX_STARVE + 1);
  logic [SW-1:0] starve_cnt;
  logic          i_legal, d_legal, i_win, d_win, legal, access;
  logic          resp_valid, resp_port;
  resp_kind_t    resp_kind;
  mem_req_check #(.MEM_BYTES(MEM_BYTES)) u_i_chk (.addr(bus.i_addr), .width(bus.i_width), .legal(i_legal));
  mem_req_check #(.MEM_BYTES(MEM_BYTES)) u_d_chk (.addr(bus.d_addr), .width(bus.d_width), .legal(d_legal));
  always_comb begin
    i_win = !reset && bus.i_req && (!bus.d_req || starve_cnt == SW'(MAX_STARVE));
    d_win = !reset && bus.d_req && !i_win;
    legal = d_win ? d_legal : i_legal;
    access = (i_win || d_win) && legal;
    bus.i_gnt = i_win;
    bus.d_gnt = d_win;
    bus.m_address = access ? (d_win ? bus.d_addr : bus.i_addr) : '0;
    bus.m_width = access ? (d_win ? bus.d_width : bus.i_width) : '0;
    bus.m_write = access && (d_win ? bus.d_write : bus.i_write);
    bus.m_data_in = access ? (d_win ? bus.d_wdata : bus.i_wdata) : '0;
    bus.i_rvalid = resp_valid && resp_port == PORT_I;
    bus.d_rvalid = resp_valid && resp_port == PORT_D;
    bus.i_rdata = bus.i_rvalid && resp_kind == RK_READ ? bus.m_data_out : '0;
    bus.d_rdata = bus.d_rvalid && resp_kind == RK_READ ? bus.m_data_out : '0;
    bus.i_err = bus.i_rvalid && resp_kind == RK_ERR;
    bus.d_err = bus.d_rvalid && resp_kind == RK_ERR;
  end
  // The response kind is fixed at grant time; memory read data arrives one cycle later
  always_ff @(posedge clock) begin
    if (reset) begin
      resp_valid <= 1'b0;
      resp_port <= PORT_I;
      resp_kind <= RK_READ;
      starve_cnt <= '0;
    end else begin
      resp_valid <= i_win || d_win;
      resp_port <= d_win ? PORT_D : PORT_I;
      resp_kind <= !legal ? RK_ERR : (d_win ? bus.d_write : bus.i_write) ? RK_WRITE : RK_READ;
      starve_cnt <= !(bus.i_req && !i_win) ? '0 : starve_cnt == SW'(MAX_STARVE) ? starve_cnt : starve_cnt + 1'b1;
    end
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter MAX_STARVE, default 4, meaning the number of consecutive lost contests before the instruction port wins.
REQ-002 SHALL have parameter MEM_BYTES, default 1024, meaning the byte size of the shared Memory; addresses at or above it are illegal.
REQ-003 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have ports i_req / d_req, input, 1 each, request from the instruction / data requester.
REQ-006 SHALL have ports i_addr / d_addr, input, 32 each, byte address.
REQ-007 SHALL have ports i_width / d_width, input, 4 each, access size in bytes; legal values are 1, 2 and 4.
REQ-008 SHALL have ports i_write / d_write, input, 1 each, write enable.
REQ-009 SHALL have ports i_wdata / d_wdata, input, 32 each, write data.
REQ-010 SHALL have ports i_gnt / d_gnt, output, 1 each, combinational request-accepted strobe.
REQ-011 SHALL have ports i_rvalid / d_rvalid, output, 1 each, response valid.
REQ-012 SHALL have ports i_rdata / d_rdata, output, 32 each, response data.
REQ-013 SHALL have ports i_err / d_err, output, 1 each, response error flag, qualified by rvalid.
REQ-014 SHALL have ports m_address (32), m_width (4), m_write (1) and m_data_in (32), outputs, driving the shared Memory.
REQ-015 SHALL have port m_data_out, input, 32, the Memory's registered read data.

Function
REQ-016 SHALL grant at most one port per cycle; gnt is asserted in the same cycle as the accepted req.
REQ-017 Requesters SHALL hold req and all request fields stable until gnt; the arbiter SHALL not latch requests.
REQ-018 SHALL grant the data port when only d_req is high, and the instruction port when only i_req is high.
REQ-019 When both are high, SHALL grant the data port unless starve_cnt == MAX_STARVE, in which case it SHALL grant the instruction port.
REQ-020 starve_cnt SHALL increment (saturating at MAX_STARVE) each cycle i_req is high without i_gnt, and SHALL clear on i_gnt or when i_req is low.
REQ-021 For a granted legal request, SHALL drive m_address/m_width/m_write/m_data_in from the winner's fields that cycle.
REQ-022 With no grant or an illegal request, SHALL drive m_width=0, m_write=0, m_address=0, m_data_in=0.
REQ-023 A request SHALL be illegal if any of: width not in {1,2,4}; width 2 with addr[0]=1; width 4 with addr[1:0]!=0; addr >= MEM_BYTES.
REQ-024 An illegal request SHALL still be granted and consume the slot, with no Memory access.
REQ-025 Every grant SHALL produce exactly one rvalid pulse on the same port in the next cycle (latency 1); back-to-back grants SHALL give back-to-back rvalids.
REQ-026 Legal read response: rdata = m_data_out, err=0; legal write response: rdata=0, err=0; illegal response: rdata=0, err=1.
REQ-027 Outside rvalid cycles, rdata SHALL be 0 and err SHALL be 0.
REQ-028 Response ownership SHALL be tracked by registered resp_valid, resp_port, resp_kind (read / write / error) captured at grant.

Reset
REQ-029 While reset is high: gnt=0, Memory outputs idle per REQ-022, and no request is granted.
REQ-030 On the reset edge, resp_valid and starve_cnt SHALL clear to 0; a response pending at reset SHALL be dropped, so rvalid=0 in the cycle after reset.

Structure
REQ-031 A shared package rv_mem_pkg SHALL hold the width codes (1/2/4), the port-id constants (PORT_I, PORT_D), the resp_kind encoding and MEM_BYTES.
REQ-032 Legality checking SHALL be one sub-module, mem_req_check (addr, width -> legal), instantiated once per port.

Verification
REQ-033 d_req read at 0x10 width 4 with Memory word 0xDEADBEEF -> d_gnt in cycle t, d_rvalid in t+1 with d_rdata=0xDEADBEEF, err=0.
REQ-034 i_req and d_req held high for 10 cycles -> d_gnt for 4 cycles, i_gnt on the 5th, then the pattern repeats; no double grant in any cycle.
REQ-035 d_req write at 0x20 width 1 with wdata 0xA5, then read at 0x20 width 1 -> write rvalid with rdata=0, then read rdata=0x000000A5.
REQ-036 d_req read at 0x22 width 4 -> d_gnt, m_width=0, next cycle d_rvalid=1, d_err=1, d_rdata=0; also addr 0x400 -> err=1.
REQ-037 i_req granted at cycle t with reset asserted at edge t+1 -> i_rvalid=0 in cycle t+1, starve_cnt=0.
REQ-038 i_req held high with streaming reads at 0x0, 0x4, 0x8 -> i_gnt every cycle, i_rvalid every cycle, with rdata matching each address.
